// File: rtl/scct_mctr_pkg.sv
// Shared constants for the SCCT multi-channel timer.
// Register indices, CTRL/STAT bit positions, default widths.
// Optional feature macro: SCCT_MCTR_COMPARE_EN (compare unit).
package scct_mctr_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int CTR_W_DEF  = 32;
  localparam int PSC_W_DEF  = 16;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_PSC  = 3'd1;
  localparam logic [2:0] REG_CNT  = 3'd2;
  localparam logic [2:0] REG_CMP  = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_OVF_IE = 1;
  localparam int CTRL_CMP_IE = 2;

  localparam int STAT_OVF = 0;
  localparam int STAT_CMP = 1;

`ifdef SCCT_MCTR_COMPARE_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  // Writable bits; compare-related bits vanish without the compare unit.
  localparam logic [2:0] CTRL_MASK = CMP_EN ? 3'b111 : 3'b011;
  localparam logic [1:0] STAT_MASK = CMP_EN ? 2'b11 : 2'b01;

endpackage

// File: rtl/scct_mctr_channel.sv
// One timer channel: prescaler, counter, CTRL/PSC/CMP/STAT, irq.
// Ports: clk, rst (async, high), wen (channel-selected), idx,
// wdata, rval (combinational readback of idx), cnt, tick, irq.
// Compare unit built only with SCCT_MCTR_COMPARE_EN.
module scct_mctr_channel
  import scct_mctr_pkg::*;
#(
  parameter int CTR_W  = CTR_W_DEF,
  parameter int PSC_W  = PSC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [2:0]        idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rval,
  output logic [CTR_W-1:0]  cnt,
  output logic              tick,
  output logic              irq
);

  logic [2:0]       ctrl;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_sh;
  logic [PSC_W-1:0] pcount;
  logic [1:0]       stat;
  logic             run;
  logic             hit;
  logic             wr_ctrl;
  logic             wr_psc;
  logic             wr_cnt;
  logic             wr_stat;
  logic [CTR_W-1:0] cnt_inc;
  logic [1:0]       set_f;
  logic [1:0]       clr_f;

  assign run     = ctrl[CTRL_RUN];
  assign hit     = run && (pcount == psc_sh);
  assign cnt_inc = cnt + CTR_W'(1);

  assign wr_ctrl = wen && (idx == REG_CTRL);
  assign wr_psc  = wen && (idx == REG_PSC);
  assign wr_cnt  = wen && (idx == REG_CNT);
  assign wr_stat = wen && (idx == REG_STAT);

  assign clr_f = wr_stat ? (wdata[1:0] & STAT_MASK) : 2'b00;

  // A CNT write overrides a same-edge increment, so that increment
  // never lands and raises no flag.
  assign set_f[STAT_OVF] = hit && !wr_cnt && (&cnt);

`ifdef SCCT_MCTR_COMPARE_EN
  logic [CTR_W-1:0] cmp;
  logic             wr_cmp;

  assign wr_cmp = wen && (idx == REG_CMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp <= '0;
    end else if (wr_cmp) begin
      cmp <= wdata[CTR_W-1:0];
    end
  end

  assign set_f[STAT_CMP] = hit && !wr_cnt &&
                           (cnt_inc == cmp);
  assign irq = (stat[STAT_OVF] & ctrl[CTRL_OVF_IE]) |
               (stat[STAT_CMP] & ctrl[CTRL_CMP_IE]);
`else
  assign set_f[STAT_CMP] = 1'b0;
  assign irq = stat[STAT_OVF] & ctrl[CTRL_OVF_IE];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl   <= '0;
      psc    <= '0;
      psc_sh <= '0;
      pcount <= '0;
      cnt    <= '0;
      stat   <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= hit;
      // Set beats a same-edge write-1-to-clear.
      stat <= (stat & ~clr_f) | set_f;
      if (wr_ctrl) begin
        ctrl <= wdata[2:0] & CTRL_MASK;
      end
      if (wr_psc) begin
        psc <= wdata[PSC_W-1:0];
      end
      // The shadow reloads only at period end, so a PSC write
      // never disturbs the period in progress.
      if (hit) begin
        pcount <= '0;
        psc_sh <= psc;
      end else if (run) begin
        pcount <= pcount + PSC_W'(1);
      end
      if (wr_cnt) begin
        cnt <= wdata[CTR_W-1:0];
      end else if (hit) begin
        cnt <= cnt_inc;
      end
    end
  end

  always_comb begin
    rval = '0;
    unique case (1'b1)
      (idx == REG_CTRL): rval = DATA_W'(ctrl);
      (idx == REG_PSC):  rval = DATA_W'(psc);
      (idx == REG_CNT):  rval = DATA_W'(cnt);
`ifdef SCCT_MCTR_COMPARE_EN
      (idx == REG_CMP):  rval = DATA_W'(cmp);
`endif
      (idx == REG_STAT): rval = DATA_W'(stat);
      default:           rval = '0;
    endcase
  end

endmodule

// File: rtl/scct_multi_counter.sv
// N_CH-channel prescaled timer behind one register port.
// Ports: clk, rst (async, high), wen, ren, addr {ch, reg[2:0]},
// wdata, rdata/rvalid (registered), count_o, tick_o, irq_o,
// irq_any_o. Compare unit: define SCCT_MCTR_COMPARE_EN.
module scct_multi_counter
  import scct_mctr_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int CTR_W  = CTR_W_DEF,
  parameter int PSC_W  = PSC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = $clog2(N_CH) + 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic                    ren,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic [N_CH*CTR_W-1:0]   count_o,
  output logic [N_CH-1:0]         tick_o,
  output logic [N_CH-1:0]         irq_o,
  output logic                    irq_any_o
);

  logic [AW-1:0]     ch_sel;
  logic [N_CH-1:0]   ch_hit;
  logic [DATA_W-1:0] rval [N_CH];
  logic [DATA_W-1:0] rd_mux;

  // Channel numbers at or above N_CH match nothing: reads give 0,
  // writes are dropped.
  assign ch_sel = addr >> 3;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_hit[k] = (ch_sel == AW'(k));

    scct_mctr_channel #(
      .CTR_W  (CTR_W),
      .PSC_W  (PSC_W),
      .DATA_W (DATA_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .wen   (wen && ch_hit[k]),
      .idx   (addr[2:0]),
      .wdata (wdata),
      .rval  (rval[k]),
      .cnt   (count_o[k*CTR_W +: CTR_W]),
      .tick  (tick_o[k]),
      .irq   (irq_o[k])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_hit[i]) begin
        rd_mux = rval[i];
      end
    end
  end

  // Sampled from pre-edge state, so a same-edge write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      rdata  <= ren ? rd_mux : '0;
    end
  end

  assign irq_any_o = |irq_o;

endmodule

// File: doc/scct_multi_counter.md
# scct_multi_counter

Parametrised multi-channel timer: N_CH independent prescaled up-counters, each with an overflow flag, an optional compare-match flag, and interrupt enables, all behind a single register port. It is the successor to the single-channel SCCT counter and provides per-channel tick strobes and counter values to downstream SCCT logic, plus a combined interrupt line.

## Interface
- N_CH, 4, number of channels (1..16)
- CTR_W, 32, counter width (≤ DATA_W)
- PSC_W, 16, prescaler width (≤ DATA_W)
- DATA_W, 32, register bus width
- AW, $clog2(N_CH)+3, register address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wen  in  1  register write strobe
- ren  in  1  register read strobe
- addr  in  AW  {channel, reg[2:0]}
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, registered
- rvalid  out  1  rdata valid pulse
- count_o  out  N_CH*CTR_W  counter values; channel k in slice [k*CTR_W +: CTR_W]
- tick_o  out  N_CH  one-cycle pulse per channel on each counter increment
- irq_o  out  N_CH  per-channel interrupt, level
- irq_any_o  out  1  OR of irq_o

## Operation
- Per-channel registers by reg index:
  - 0 CTRL: bit0 RUN, bit1 OVF_IE, bit2 CMP_IE.
  - 1 PSC.
  - 2 CNT: read returns the live value; write loads the counter.
  - 3 CMP.
  - 4 STAT: bit0 OVF, bit1 CMP; write 1 to clear.
  - Indices 5..7 and channels ≥ N_CH read 0; writes to them are ignored.
- Prescaler per channel: pcount increments each cycle while RUN=1. When pcount == psc_shadow:
  - the counter increments (mod 2^CTR_W);
  - pcount goes to 0;
  - psc_shadow ← PSC;
  - tick_o pulses.
  - Net effect: one increment every psc_shadow+1 cycles. A PSC write takes effect after the current period completes.
- RUN=0 holds pcount, counter and psc_shadow. tick_o stays 0.
- Overflow: an increment from 2^CTR_W−1 to 0 sets STAT.OVF.
- Compare: an increment whose new value equals CMP sets STAT.CMP. CNT and CMP writes never set flags.
- irq_o[k] = (OVF & OVF_IE) | (CMP & CMP_IE).
- Simultaneous events:
  - Flag set and W1C clear on the same edge: set wins, flag stays 1.
  - CNT write on the same edge as an increment: the write value wins, pcount goes to 0, and tick_o still pulses.
  - CTRL write clearing RUN on an increment edge: the increment happens; the hold starts next cycle.
- Reset values: all registers, pcount, psc_shadow, count_o, tick_o, irq_o, irq_any_o, rdata and rvalid are 0.
- Reset mid-operation clears everything immediately; no pending state survives.

## Timing
- Counter updates on the edge where pcount == psc_shadow. count_o, tick_o and STAT are all visible after that same edge.
- irq_o is combinational from the STAT/CTRL flops, so it asserts in the same cycle STAT is set.
- Register write: takes effect at the edge with wen=1.
- Register read: rdata and rvalid assert 1 cycle after ren and hold for exactly 1 cycle. rdata samples register state before any same-edge write.
- wen and ren in the same cycle are legal and independent.
- With PSC=0 and RUN=1 the counter increments every cycle. The first increment occurs 1 cycle after RUN is written.

## Configuration
- SCCT_MCTR_COMPARE_EN defined:
  - CMP register, STAT.CMP and CTRL.CMP_IE are implemented.
- SCCT_MCTR_COMPARE_EN undefined:
  - No compare comparators or CMP flops are built.
  - Reg 3, STAT bit1 and CTRL bit2 read 0; writes to them are ignored.
  - irq_o derives from OVF only.

## Structure
- Shared constants file: register index constants (CTRL, PSC, CNT, CMP, STAT), CTRL/STAT bit positions, default widths.
- Sub-module scct_mctr_channel holds the per-channel state:
  - prescaler, counter, CTRL/PSC/CMP/STAT registers, irq;
  - it is instantiated N_CH times in a generate loop.
- Top level contains the address decode, the registered read mux and irq_any_o.

## Test plan
- PSC=3, RUN=1 on ch0: tick_o[0] every 4 cycles; count_o ch0 = 5 after 20 cycles; other channels stay at 0.
- CNT write 0xFFFFFFFE, PSC=0, OVF_IE=1: after 2 cycles count=0, OVF=1, irq_o[0]=1, irq_any_o=1; W1C STAT=1 → irq_o[0]=0 next cycle.
- Align a W1C of OVF with the wrap edge: OVF stays 1. Align a CNT write with an increment edge: count equals the written value.
- Change PSC 1→7 mid-period: the current period stays 2 cycles, subsequent periods are 8. RUN=0 freezes the count; re-enable resumes from the held value.
- With SCCT_MCTR_COMPARE_EN: CMP=10, CMP_IE=1 → CMP flag and irq at the increment to 10. Without the macro: reg 3 reads 0 and no irq.
- Assert rst mid-count with a pending irq: all outputs are 0 immediately. A read of an unmapped address returns 0 with rvalid=1.
